// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the MIPS MEM-stage load/store unit.
//   - access size codes (SZ_BYTE/SZ_HALF/SZ_WORD, 2'b11 is illegal)
//   - FSM state encodings
//   - default word-index width of the attached Memory block
//   - helper that classifies illegal sizes and misaligned offsets
package mem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam int MEM_WORDS_LOG2_DEFAULT = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        STORE  = 3'd3,
        RESP   = 3'd4
    } lsu_state_t;

    // True when the size code is illegal or the byte offset is not a
    // natural boundary for that size. Bytes may sit at any offset.
    function automatic logic bad_size_or_alignment(input logic [1:0] size,
                                                   input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: bundle of the request/response handshake and the Memory bus.
//   slave  modport: the load/store unit (accepts requests, drives Memory).
//   master modport: the datapath side plus the Memory model (issues
//                   requests, supplies the combinational read word).
// Signals:
//   req_valid/req_ready  request handshake
//   req_we, req_size, req_signed, req_addr, req_wdata  request fields
//   resp_valid, resp_err, resp_rdata                   completion
//   mem_ren, mem_wen, mem_addr, mem_din                Memory strobes/data
//   mem_dout                                           Memory read word
interface mem_lsu_if #(
    parameter int N = 32
);

    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [1:0]   req_size;
    logic         req_signed;
    logic [N-1:0] req_addr;
    logic [N-1:0] req_wdata;

    logic         resp_valid;
    logic         resp_err;
    logic [N-1:0] resp_rdata;

    logic         mem_ren;
    logic         mem_wen;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_din;
    logic [N-1:0] mem_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  mem_dout,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_ren, mem_wen, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output mem_dout,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_ren, mem_wen, mem_addr, mem_din
    );

endinterface

// File: rtl/mem_lsu_align.sv
// lsu_align: combinational big-endian lane handling for the load/store unit.
//   word      : 32-bit word read from Memory
//   wdata     : store data, right-justified
//   offset    : byte offset within the word (addr[1:0])
//   size      : SZ_BYTE / SZ_HALF / SZ_WORD
//   is_signed : sign-extend byte/half loads
//   rdata     : extracted and extended load data
//   merged    : word with the store lane replaced, other bytes preserved
// Lane mapping is MIPS big-endian: offset 0 is bits [31:24].
// N is fixed at 32 for MIPS32, so lane positions are written out literally.
module lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] word,
    input  logic [N-1:0] wdata,
    input  logic [1:0]   offset,
    input  logic [1:0]   size,
    input  logic         is_signed,
    output logic [N-1:0] rdata,
    output logic [N-1:0] merged
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word[31:24];
        case (offset)
            2'd0: lane_byte = word[31:24];
            2'd1: lane_byte = word[23:16];
            2'd2: lane_byte = word[15:8];
            2'd3: lane_byte = word[7:0];
            default: lane_byte = word[31:24];
        endcase
        // Halves are only ever at offset 0 or 2, so bit 1 picks the lane.
        lane_half = offset[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        rdata = '0;
        case (size)
            SZ_BYTE: rdata = {{24{is_signed & lane_byte[7]}}, lane_byte};
            SZ_HALF: rdata = {{16{is_signed & lane_half[15]}}, lane_half};
            SZ_WORD: rdata = word;
            default: rdata = '0;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0: merged[31:24] = wdata[7:0];
                    2'd1: merged[23:16] = wdata[7:0];
                    2'd2: merged[15:8]  = wdata[7:0];
                    2'd3: merged[7:0]   = wdata[7:0];
                    default: merged = word;
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) begin
                    merged[15:0] = wdata[15:0];
                end else begin
                    merged[31:16] = wdata[15:0];
                end
            end
            SZ_WORD: merged = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the MIPS MEM stage and word-addressed
// Memory. One request at a time; sub-word stores are read-modify-write.
// Ports:
//   clock : posedge clock
//   reset : asynchronous, active-low
//   bus   : mem_lsu_if.slave (request/response handshake and Memory bus)
// Every output on the bus is driven straight from a flop. The single
// always_comb computes the next value of each flop from the next state,
// so strobes line up with the state they belong to.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int N              = 32,
    parameter int MEM_WORDS_LOG2 = MEM_WORDS_LOG2_DEFAULT
) (
    input logic     clock,
    input logic     reset,
    mem_lsu_if.slave bus
);

    lsu_state_t   state_q, state_d;

    logic [1:0]   size_q, size_d;
    logic         signed_q, signed_d;
    logic [1:0]   offset_q, offset_d;
    logic [N-1:0] wdata_q, wdata_d;

    logic         ready_q, ready_d;
    logic         resp_valid_q, resp_valid_d;
    logic         resp_err_q, resp_err_d;
    logic [N-1:0] resp_rdata_q, resp_rdata_d;
    logic         mem_ren_q, mem_ren_d;
    logic         mem_wen_q, mem_wen_d;
    logic [N-1:0] mem_addr_q, mem_addr_d;
    logic [N-1:0] mem_din_q, mem_din_d;

    logic         accept;
    logic         out_of_range;
    logic         req_bad;
    logic [N-1:0] load_data;
    logic [N-1:0] merged_word;

    // Lane handling works on the latched request against the live read word.
    lsu_align #(.N(N)) u_align (
        .word      (bus.mem_dout),
        .wdata     (wdata_q),
        .offset    (offset_q),
        .size      (size_q),
        .is_signed (signed_q),
        .rdata     (load_data),
        .merged    (merged_word)
    );

    // ready_q is still low on the first IDLE cycle after reset, which keeps
    // a request held across reset release from being taken too early.
    assign accept       = (state_q == IDLE) && ready_q && bus.req_valid;
    assign out_of_range = (bus.req_addr >> (MEM_WORDS_LOG2 + 2)) != '0;
    assign req_bad      = bad_size_or_alignment(bus.req_size, bus.req_addr[1:0])
                          || out_of_range;

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        signed_d     = signed_q;
        offset_d     = offset_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    size_d     = bus.req_size;
                    signed_d   = bus.req_signed;
                    offset_d   = bus.req_addr[1:0];
                    wdata_d    = bus.req_wdata;
                    mem_addr_d = {2'b00, bus.req_addr[N-1:2]};
                    if (req_bad) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        state_d      = RESP;
                    end else if (!bus.req_we) begin
                        state_d = LOAD;
                    end else if (bus.req_size == SZ_WORD) begin
                        mem_din_d = bus.req_wdata;
                        state_d   = STORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
                state_d      = RESP;
            end
            RMW_RD: begin
                mem_din_d = merged_word;
                state_d   = STORE;
            end
            STORE: begin
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d   = (state_d == IDLE);
        mem_ren_d = (state_d == LOAD) || (state_d == RMW_RD);
        mem_wen_d = (state_d == STORE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            offset_q     <= 2'b00;
            wdata_q      <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_ren_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            offset_q     <= offset_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_ren_q    <= mem_ren_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_ren    = mem_ren_q;
    assign bus.mem_wen    = mem_wen_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;

endmodule
